// File: rtl/exp_batch_ctrl.sv
// exp_batch_ctrl: batch sequencer driving the exponential datapath wrapper.
// Optional build macro EXP_TIMEOUT_EN adds a WAIT watchdog and sticky err port.
module exp_batch_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int NUM_SAMPLES = 8,
  parameter int SH_STEPS    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              dpDone,
  output logic              ld,
  output logic              shEn,
  output logic              uiRegLd,
  output logic              start,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              wrEn,
  output logic              busy,
`ifdef EXP_TIMEOUT_EN
  output logic              err,
`endif
  output logic              allDone
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_START,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [3:0] SH_LAST =
    4'((SH_STEPS > 0) ? SH_STEPS - 1 : 0);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        sh_cnt;
  logic              dpDone_q;
  logic              dp_rise;

`ifdef EXP_TIMEOUT_EN
  localparam int WD_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wdog;
`else
  // Without the watchdog TIMEOUT_CYC has no effect on the logic.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  // Done is only honoured on its rising edge, so a level left high is ignored.
  assign dp_rise = dpDone & ~dpDone_q;
  assign rdAddr  = idx;
  assign busy    = (state != S_IDLE);

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      sh_cnt   <= '0;
      dpDone_q <= 1'b0;
      wrAddr   <= '0;
      ld       <= 1'b0;
      shEn     <= 1'b0;
      uiRegLd  <= 1'b0;
      start    <= 1'b0;
      wrEn     <= 1'b0;
      allDone  <= 1'b0;
`ifdef EXP_TIMEOUT_EN
      wdog     <= '0;
      err      <= 1'b0;
`endif
    end else begin
      dpDone_q <= dpDone;
      ld       <= 1'b0;
      shEn     <= 1'b0;
      uiRegLd  <= 1'b0;
      start    <= 1'b0;
      wrEn     <= 1'b0;
      allDone  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_LOAD;
            idx     <= '0;
            ld      <= 1'b1;
            uiRegLd <= 1'b1;
`ifdef EXP_TIMEOUT_EN
            err     <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (SH_STEPS == 0) begin
            state <= S_START;
            start <= 1'b1;
          end else begin
            state  <= S_SHIFT;
            shEn   <= 1'b1;
            sh_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (sh_cnt == SH_LAST) begin
            state <= S_START;
            start <= 1'b1;
          end else begin
            sh_cnt <= sh_cnt + 4'd1;
            shEn   <= 1'b1;
          end
        end
        S_START: begin
          state <= S_WAIT;
`ifdef EXP_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        S_WAIT: begin
          if (dp_rise) begin
            state  <= S_WRITE;
            wrEn   <= 1'b1;
            wrAddr <= idx;
          end
`ifdef EXP_TIMEOUT_EN
          // Forced write keeps the address sequence aligned.
          else if (wdog == WD_LAST) begin
            state  <= S_WRITE;
            wrEn   <= 1'b1;
            wrAddr <= idx;
            err    <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        S_WRITE: begin
          if (idx == IDX_LAST) begin
            state   <= S_FIN;
            allDone <= 1'b1;
          end else begin
            state   <= S_LOAD;
            idx     <= idx + 1'b1;
            ld      <= 1'b1;
            uiRegLd <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          idx   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
